hart_sched: RTL
===============

// Module: hart_sched
// PURPOSE
// - Hart scheduler/controller for the FMRT Mini Core fetch front end; drives the hart_id, hstart, hidle, hs_id, hs_pc inputs of the IF/ID register.
// - Tracks per-hart state (IDLE/ACTIVE/PEND), services start/kill/pend/resume requests from ID/EX/MEM, and picks the issuing hart round-robin among ACTIVE harts.
// PARAMETERS
// - HART_NUM   4  number of hardware threads (power of two)
// - HART_ID_W  2  hart index width, log2(HART_NUM)
// - PC_W      32  program counter width (`WORD_DATA_W)
// PORTS
// - clk         in   1          core clock
// - reset       in   1          asynchronous, active-high reset
// - stall       in   1          pipeline stall; freezes hart_id selection
// - hs_req      in   1          hart start request (from ID)
// - hs_req_id   in   HART_ID_W  hart to start
// - hs_req_pc   in   PC_W       start PC for that hart
// - hk_req      in   1          hart kill request (hart -> IDLE)
// - hk_id       in   HART_ID_W  hart to kill
// - hp_set      in   1          pend request (e.g. cache miss), hart -> PEND
// - hp_set_id   in   HART_ID_W  hart to pend
// - hp_clr      in   1          resume request, PEND -> ACTIVE
// - hp_clr_id   in   HART_ID_W  hart to resume
// - hart_id     out  HART_ID_W  hart issuing fetch this cycle (registered)
// - issue_en    out  1          1 when hart_id is ACTIVE (fetch is valid)
// - hstart      out  1          = hs_req, forwarded to IF
// - hs_id       out  HART_ID_W  = hs_req_id
// - hs_pc       out  PC_W       = hs_req_pc
// - hidle       out  1          combinational: state[hs_req_id]==IDLE
// - hact_vec    out  HART_NUM   bit i = 1 when hart i ACTIVE (registered)
// BEHAVIOUR
// - State per hart, 2 bits: IDLE=2'b00, ACTIVE=2'b01, PEND=2'b10; 2'b11 illegal, decoded as IDLE.
// - Reset (async): hart 0 ACTIVE, all others IDLE; hart_id=0; hact_vec=...0001; issue_en=1.
// - Per-hart next state, priority kill > pend_set > pend_clr > start:
//   kill: any -> IDLE. pend_set: ACTIVE -> PEND (ignored if IDLE/PEND).
//   pend_clr: PEND -> ACTIVE (ignored otherwise). start: IDLE -> ACTIVE only; start to non-IDLE ignored.
// - Distinct ids in the same cycle are all applied; same id resolved by the priority above.
// - Start is also ignored when hs_req_id == current hart_id (same gate as IF PC load); hidle still reports raw state.
// - State updates are visible one cycle later; hstart/hs_id/hs_pc/hidle are same-cycle combinational.
// - Selection (registered, uses current-state vector): if stall=1 hold hart_id.
//   else hart_id <= first ACTIVE hart scanning hart_id+1, +2, ..., wrapping modulo HART_NUM, including hart_id itself last.
//   If no hart ACTIVE: hold hart_id, issue_en=0 next cycle.
// - issue_en = state[hart_id]==ACTIVE (from registered state), so a kill/pend of the current hart drops issue_en the next cycle even while stalled.
// - All harts killed: core idles (issue_en=0) until a start request arrives; no auto-restart of hart 0.
// - Reset mid-operation: every state and hart_id returns to reset values immediately; pending requests are discarded.
// STRUCTURE
// - hart_ctrl.h: state encodings (HART_IDLE/ACTIVE/PEND), HART_NUM/HART_ID_W defaults, HART_ID_B/HART_NUM_B bus macros.
// - One sub-module: hart_rr_arb (HART_NUM-wide round-robin picker: req vector + last grant -> next grant, valid).
// - Per-hart state regs and request decode stay in hart_sched.
// TESTING
// - Reset, no requests -> hart_id stays 0, issue_en=1, hact_vec=4'b0001 for 10 cycles.
// - hs_req id=2 pc=0x100 at cycle 1 -> hidle=1 that cycle; from cycle 2 hact_vec=4'b0101, and hart_id alternates 0,2,0,2.
// - Harts 0-3 ACTIVE, stall=1 for 3 cycles at hart_id=1 -> hart_id held at 1; after release, sequence 2,3,0,1.
// - hp_set id=1 and hp_clr id=1 in the same cycle while 1 ACTIVE -> state PEND; next-cycle hp_clr id=1 -> ACTIVE again.
// - hk_req id=0 with hs_req id=0 in the same cycle (hart 0 ACTIVE) -> hart 0 IDLE, issue_en=0, hart_id held at 0.
// - Assert reset while hact_vec=4'b1111 and hart_id=3 -> outputs return asynchronously to hart_id=0, hact_vec=4'b0001.

Source files
------------

// File: rtl/hart_sched_pkg.sv
// hart_sched_pkg: hart state encodings and scheduler sizing shared by the hart scheduler slice.
package hart_sched_pkg;
   localparam int HART_NUM  = 4;
   localparam int HART_ID_W = 2;
   localparam int PC_W      = 32;
   localparam logic [1:0] HART_IDLE   = 2'b00;
   localparam logic [1:0] HART_ACTIVE = 2'b01;
   localparam logic [1:0] HART_PEND   = 2'b10;
   // 2'b11 is illegal and treated as IDLE everywhere
   function automatic logic hart_live(input logic [1:0] s);
      return (s == HART_ACTIVE) || (s == HART_PEND);
   endfunction
endpackage

// File: rtl/hart_sched_if.sv
// hart_sched_if: request inputs from ID/EX/MEM and fetch-side outputs of the hart scheduler.
interface hart_sched_if;
   import hart_sched_pkg::*;
   logic                 stall;
   logic                 hs_req;
   logic [HART_ID_W-1:0] hs_req_id;
   logic [PC_W-1:0]      hs_req_pc;
   logic                 hk_req;
   logic [HART_ID_W-1:0] hk_id;
   logic                 hp_set;
   logic [HART_ID_W-1:0] hp_set_id;
   logic                 hp_clr;
   logic [HART_ID_W-1:0] hp_clr_id;
   logic [HART_ID_W-1:0] hart_id;
   logic                 issue_en;
   logic                 hstart;
   logic [HART_ID_W-1:0] hs_id;
   logic [PC_W-1:0]      hs_pc;
   logic                 hidle;
   logic [HART_NUM-1:0]  hact_vec;
   modport master (
      output stall, hs_req, hs_req_id, hs_req_pc, hk_req, hk_id, hp_set, hp_set_id, hp_clr, hp_clr_id,
      input  hart_id, issue_en, hstart, hs_id, hs_pc, hidle, hact_vec
   );
   modport slave (
      input  stall, hs_req, hs_req_id, hs_req_pc, hk_req, hk_id, hp_set, hp_set_id, hp_clr, hp_clr_id,
      output hart_id, issue_en, hstart, hs_id, hs_pc, hidle, hact_vec
   );
endinterface

// File: rtl/hart_sched_rr_arb.sv
// hart_sched_rr_arb: round-robin picker; first requester after last_i, wrapping, last_i itself checked last.
module hart_sched_rr_arb
   import hart_sched_pkg::*;
(
   input  logic [HART_NUM-1:0]  req_i,
   input  logic [HART_ID_W-1:0] last_i,
   output logic [HART_ID_W-1:0] grant_o,
   output logic                 valid_o
);
   logic [HART_ID_W-1:0] idx;
   // scan farthest-first so the nearest requester is the final assignment
   always_comb begin
      grant_o = last_i;
      valid_o = 1'b0;
      idx = last_i;
      for (int k = HART_NUM; k >= 1; k--) begin
         idx = last_i + HART_ID_W'(k);
         if (req_i[idx]) begin
            grant_o = idx;
            valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hart_sched.sv
// hart_sched: per-hart IDLE/ACTIVE/PEND tracking and round-robin fetch hart selection.
module hart_sched
   import hart_sched_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   hart_sched_if.slave  bus
);
   logic [1:0]           state_q [HART_NUM];
   logic [1:0]           state_d [HART_NUM];
   logic [HART_ID_W-1:0] hart_id_q, hart_id_d, grant;
   logic [HART_NUM-1:0]  act;
   logic                 valid;
   always_comb begin
      for (int i = 0; i < HART_NUM; i++) begin
         act[i] = state_q[i] == HART_ACTIVE;
      end
   end
   // at most one of pend_set/pend_clr/start can apply to a given state, so only kill needs ordering
   always_comb begin
      for (int i = 0; i < HART_NUM; i++) begin
         state_d[i] =
            (bus.hk_req && bus.hk_id == HART_ID_W'(i)) ? HART_IDLE :
            (bus.hp_set && bus.hp_set_id == HART_ID_W'(i) && state_q[i] == HART_ACTIVE) ? HART_PEND :
            (bus.hp_clr && bus.hp_clr_id == HART_ID_W'(i) && state_q[i] == HART_PEND) ? HART_ACTIVE :
            (bus.hs_req && bus.hs_req_id == HART_ID_W'(i) && !hart_live(state_q[i]) &&
             bus.hs_req_id != hart_id_q) ? HART_ACTIVE :
            hart_live(state_q[i]) ? state_q[i] : HART_IDLE;
      end
   end
   hart_sched_rr_arb u_arb (
      .req_i   (act),
      .last_i  (hart_id_q),
      .grant_o (grant),
      .valid_o (valid)
   );
   assign hart_id_d = (!bus.stall && valid) ? grant : hart_id_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < HART_NUM; i++) begin
            state_q[i] <= (i == 0) ? HART_ACTIVE : HART_IDLE;
         end
         hart_id_q <= '0;
      end else begin
         for (int i = 0; i < HART_NUM; i++) begin
            state_q[i] <= state_d[i];
         end
         hart_id_q <= hart_id_d;
      end
   end
   assign bus.hart_id  = hart_id_q;
   assign bus.issue_en = act[hart_id_q];
   assign bus.hact_vec = act;
   assign bus.hstart   = bus.hs_req;
   assign bus.hs_id    = bus.hs_req_id;
   assign bus.hs_pc    = bus.hs_req_pc;
   assign bus.hidle    = !hart_live(state_q[bus.hs_req_id]);
endmodule
